jedro_1_mem_arbiter: RTL and testbench

//  Shares one single-port synchronous RAM between the jedro_1 instruction-fetch port (read-only)
//  and the load/store port (read/write). Sits between jedro_1_top and the memory macro,
//  so cores and benches can use one unified memory. Fixed data-over-instr priority, bounded starvation.

---
 rtl/jedro_1_arb_pkg.sv | 21 ++
 rtl/jedro_1_arb_starve_cnt.sv | 26 ++
 rtl/jedro_1_mem_arbiter.sv | 115 +++++++++++
 tb/tb_jedro_1_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jedro_1_arb_pkg.sv
// Shared types and address helpers for the jedro_1 memory arbiter.
// Addresses pass through the helpers zero-extended to 64 bits so any ADDR_WIDTH up to 64 fits.
package jedro_1_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INSTR = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  localparam logic [3:0] BE_ALL = 4'hF;

  function automatic logic [63:0] word_addr(input logic [63:0] byte_addr);
    return byte_addr >> 2;
  endfunction

  function automatic logic in_range(input logic [63:0] byte_addr, input int unsigned depth);
    return byte_addr < ({32'd0, depth} << 2);
  endfunction

endpackage

// File: rtl/jedro_1_arb_starve_cnt.sv
// Counts consecutive denied instruction-request cycles; raises force_o at STARVE_LIMIT.
module jedro_1_arb_starve_cnt #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_req_i,
  input  logic i_gnt_i,
  output logic force_o
);

  logic [3:0] cnt_q;

  assign force_o = (cnt_q == 4'(STARVE_LIMIT));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (!i_req_i || i_gnt_i) begin
      cnt_q <= '0;
    end else if (!force_o) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

endmodule

// File: rtl/jedro_1_mem_arbiter.sv
// Shares one single-port RAM between instr fetch and load/store, data first, bounded instr starvation.
// Optional perf counters enabled by defining JEDRO_1_MEM_ARB_PERF_EN.
module jedro_1_mem_arbiter
  import jedro_1_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int MEM_DEPTH    = 1024,
  parameter int STARVE_LIMIT = 4,
  localparam int AW          = $clog2(MEM_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  i_req_i,
  input  logic [ADDR_WIDTH-1:0] i_addr_i,
  output logic                  i_gnt_o,
  output logic                  i_rvalid_o,
  output logic [DATA_WIDTH-1:0] i_rdata_o,
  output logic                  i_err_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [3:0]            d_be_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  output logic                  d_err_o,
  output logic                  ram_en_o,
  output logic [3:0]            ram_we_o,
  output logic [AW-1:0]         ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
`ifdef JEDRO_1_MEM_ARB_PERF_EN
  ,
  output logic [31:0]           perf_conflict_o,
  output logic [31:0]           perf_forced_o
`endif
);

  // Handshake: a request is accepted in the cycle *_gnt_o is high; the
  // matching *_rvalid_o follows exactly one cycle later and is never stalled.
  logic        i_req_v, d_req_v;
  logic        force_i;
  logic        i_gnt, d_gnt;
  logic [63:0] sel_addr;
  logic        sel_ok;
  owner_e      owner_q;
  logic        err_q, wr_q;

  assign i_req_v = i_req_i & ~rst_i;
  assign d_req_v = d_req_i & ~rst_i;

  assign d_gnt = d_req_v & ~(force_i & i_req_v);
  assign i_gnt = i_req_v & ~d_gnt;

  assign i_gnt_o = i_gnt;
  assign d_gnt_o = d_gnt;

  assign sel_addr = d_gnt ? 64'(d_addr_i) : 64'(i_addr_i);
  assign sel_ok   = in_range(sel_addr, MEM_DEPTH);

  assign ram_en_o    = (i_gnt | d_gnt) & sel_ok;
  assign ram_we_o    = (d_gnt & d_we_i & sel_ok) ? d_be_i : 4'd0;
  assign ram_addr_o  = AW'(word_addr(sel_addr));
  assign ram_wdata_o = d_wdata_i;

  jedro_1_arb_starve_cnt #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .i_req_i(i_req_v),
    .i_gnt_i(i_gnt),
    .force_o(force_i)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q <= OWN_NONE;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      owner_q <= d_gnt ? OWN_DATA : (i_gnt ? OWN_INSTR : OWN_NONE);
      err_q   <= (i_gnt | d_gnt) & ~sel_ok;
      wr_q    <= d_gnt & d_we_i;
    end
  end

  // Gating with rst_i drops a response whose grant preceded a reset cycle.
  assign i_rvalid_o = (owner_q == OWN_INSTR) & ~rst_i;
  assign d_rvalid_o = (owner_q == OWN_DATA) & ~rst_i;
  assign i_err_o    = i_rvalid_o & err_q;
  assign d_err_o    = d_rvalid_o & err_q;
  assign i_rdata_o  = (i_rvalid_o & ~err_q) ? ram_rdata_i : '0;
  assign d_rdata_o  = (d_rvalid_o & ~err_q & ~wr_q) ? ram_rdata_i : '0;

`ifdef JEDRO_1_MEM_ARB_PERF_EN
  logic [31:0] conflict_q, forced_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      conflict_q <= '0;
      forced_q   <= '0;
    end else begin
      if (i_req_v && d_req_v && conflict_q != '1) conflict_q <= conflict_q + 32'd1;
      if (force_i && i_gnt && d_req_v && forced_q != '1) forced_q <= forced_q + 32'd1;
    end
  end

  assign perf_conflict_o = conflict_q;
  assign perf_forced_o   = forced_q;
`endif

endmodule

// File: tb/tb_jedro_1_mem_arbiter.sv
// Directed bench for jedro_1_mem_arbiter with a 1-cycle-latency RAM model and response scoreboard.
// Perf counter checks are included when JEDRO_1_MEM_ARB_PERF_EN is defined.
module tb_jedro_1_mem_arbiter;

  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        i_req_i;
  logic [31:0] i_addr_i;
  logic        i_gnt_o, i_rvalid_o, i_err_o;
  logic [31:0] i_rdata_o;
  logic        d_req_i, d_we_i;
  logic [3:0]  d_be_i;
  logic [31:0] d_addr_i, d_wdata_i;
  logic        d_gnt_o, d_rvalid_o, d_err_o;
  logic [31:0] d_rdata_o;
  logic        ram_en_o;
  logic [3:0]  ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata_i;
`ifdef JEDRO_1_MEM_ARB_PERF_EN
  logic [31:0] perf_conflict_o, perf_forced_o;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [32:0] i_exp_q[$];
  logic [32:0] d_exp_q[$];

  logic [31:0] mem [1024];

  jedro_1_mem_arbiter #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(1024), .STARVE_LIMIT(4)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_gnt_o(i_gnt_o),
    .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o), .i_err_o(i_err_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
    .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
`ifdef JEDRO_1_MEM_ARB_PERF_EN
    , .perf_conflict_o(perf_conflict_o), .perf_forced_o(perf_forced_o)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // 1-cycle-latency byte-writable RAM model
  always @(posedge clk) begin
    if (ram_en_o) begin
      for (int b = 0; b < 4; b++)
        if (ram_we_o[b]) mem[ram_addr_o][8*b +: 8] <= ram_wdata_o[8*b +: 8];
      if (ram_we_o == 4'd0) ram_rdata_i <= mem[ram_addr_o];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // scoreboard: responses are due one cycle after the grant that queued them
  always @(posedge clk) begin
    #3;
    check("i_rvalid", 64'(i_rvalid_o), 64'(i_exp_q.size() != 0));
    if (i_rvalid_o && i_exp_q.size() != 0)
      check("i_resp", 64'({i_err_o, i_rdata_o}), 64'(i_exp_q.pop_front()));
    else if (i_exp_q.size() != 0)
      void'(i_exp_q.pop_front());
    check("d_rvalid", 64'(d_rvalid_o), 64'(d_exp_q.size() != 0));
    if (d_rvalid_o && d_exp_q.size() != 0)
      check("d_resp", 64'({d_err_o, d_rdata_o}), 64'(d_exp_q.pop_front()));
    else if (d_exp_q.size() != 0)
      void'(d_exp_q.pop_front());
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic set_i(input logic req, input logic [31:0] addr);
    i_req_i  = req;
    i_addr_i = addr;
  endtask

  task automatic set_d(input logic req, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata);
    d_req_i   = req;
    d_we_i    = we;
    d_be_i    = be;
    d_addr_i  = addr;
    d_wdata_i = wdata;
  endtask

  task automatic check_gnt(input string tag, input logic ig, input logic dg);
    check({tag, "_i_gnt"}, 64'(i_gnt_o), 64'(ig));
    check({tag, "_d_gnt"}, 64'(d_gnt_o), 64'(dg));
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) mem[k] = 32'(k * 4 + 3);
    mem[8] = 32'h1122_3344;
    ram_rdata_i = '0;
    rst_i = 1'b1;
    set_i(1'b0, '0);
    set_d(1'b0, 1'b0, 4'd0, '0, '0);

    // reset values
    tick();
    tick();
    set_i(1'b1, 32'h10);
    at_neg();
    check_gnt("reset", 1'b0, 1'b0);
    check("reset_ram_en", 64'(ram_en_o), 64'd0);
    check("reset_ram_we", 64'(ram_we_o), 64'd0);
    check("reset_rdata", 64'({i_rdata_o, d_rdata_o}), 64'd0);
    check("reset_err", 64'({i_err_o, d_err_o}), 64'd0);
    tick();
    rst_i = 1'b0;
    set_i(1'b0, '0);
    at_neg();
    check_gnt("idle", 1'b0, 1'b0);
    tick();

    // instr-only read of word 4
    set_i(1'b1, 32'h10);
    at_neg();
    check_gnt("iread", 1'b1, 1'b0);
    check("iread_ram_en", 64'(ram_en_o), 64'd1);
    check("iread_ram_addr", 64'(ram_addr_o), 64'd4);
    check("iread_ram_we", 64'(ram_we_o), 64'd0);
    i_exp_q.push_back({1'b0, 32'h13});
    tick();
    set_i(1'b0, '0);

    // partial-byte write then read back
    set_d(1'b1, 1'b1, 4'b0011, 32'h20, 32'hAABB_CCDD);
    at_neg();
    check_gnt("dwrite", 1'b0, 1'b1);
    check("dwrite_ram_we", 64'(ram_we_o), 64'h3);
    check("dwrite_ram_addr", 64'(ram_addr_o), 64'd8);
    d_exp_q.push_back({1'b0, 32'h0});
    tick();
    set_d(1'b1, 1'b0, 4'd0, 32'h20, '0);
    at_neg();
    check_gnt("dread", 1'b0, 1'b1);
    d_exp_q.push_back({1'b0, 32'h1122_CCDD});
    tick();
    set_d(1'b0, 1'b0, 4'd0, '0, '0);
    tick();

    // contention: both requests held for 10 cycles
    set_i(1'b1, 32'h10);
    set_d(1'b1, 1'b0, 4'd0, 32'h20, '0);
    for (int c = 0; c < 10; c++) begin
      at_neg();
      check_gnt($sformatf("contend%0d", c), (c % 5) == 4, (c % 5) != 4);
      if ((c % 5) == 4) i_exp_q.push_back({1'b0, 32'h13});
      else              d_exp_q.push_back({1'b0, 32'h1122_CCDD});
      tick();
    end
    set_i(1'b0, '0);
    set_d(1'b0, 1'b0, 4'd0, '0, '0);
`ifdef JEDRO_1_MEM_ARB_PERF_EN
    at_neg();
    check("perf_conflict", 64'(perf_conflict_o), 64'd10);
    check("perf_forced", 64'(perf_forced_o), 64'd2);
`endif
    tick();

    // range boundaries: last word in range, first byte out of range
    set_d(1'b1, 1'b0, 4'd0, 32'hFFC, '0);
    at_neg();
    check_gnt("dlast", 1'b0, 1'b1);
    check("dlast_ram_addr", 64'(ram_addr_o), 64'd1023);
    d_exp_q.push_back({1'b0, 32'h0000_0FFF});
    tick();
    set_d(1'b1, 1'b0, 4'd0, 32'h1000, '0);
    at_neg();
    check_gnt("door", 1'b0, 1'b1);
    check("door_ram_en", 64'(ram_en_o), 64'd0);
    d_exp_q.push_back({1'b1, 32'h0});
    tick();
    set_d(1'b0, 1'b0, 4'd0, '0, '0);
    set_i(1'b1, 32'h0001_0000);
    at_neg();
    check_gnt("ioor", 1'b1, 1'b0);
    check("ioor_ram_en", 64'(ram_en_o), 64'd0);
    i_exp_q.push_back({1'b1, 32'h0});
    tick();

    // same-word write and fetch: data first, fetch sees new value
    set_i(1'b1, 32'h30);
    set_d(1'b1, 1'b1, BE_ALL_TB(), 32'h30, 32'hCAFE_F00D);
    at_neg();
    check_gnt("same_w", 1'b0, 1'b1);
    d_exp_q.push_back({1'b0, 32'h0});
    tick();
    set_d(1'b0, 1'b0, 4'd0, '0, '0);
    at_neg();
    check_gnt("same_r", 1'b1, 1'b0);
    i_exp_q.push_back({1'b0, 32'hCAFE_F00D});
    tick();
    set_i(1'b0, '0);
    tick();

    // reset the cycle after an instr grant discards its response
    set_i(1'b1, 32'h10);
    at_neg();
    check_gnt("rstmid", 1'b1, 1'b0);
    tick();
    rst_i = 1'b1;
    set_i(1'b0, '0);
    at_neg();
    check("rstmid_i_rvalid", 64'(i_rvalid_o), 64'd0);
    check("rstmid_i_rdata", 64'(i_rdata_o), 64'd0);
    check("rstmid_ram_en", 64'(ram_en_o), 64'd0);
    tick();
    rst_i = 1'b0;
    at_neg();
    check("postrst_i_rvalid", 64'(i_rvalid_o), 64'd0);
    check("postrst_d_rvalid", 64'(d_rvalid_o), 64'd0);
    tick();

    // recovery after reset
    set_i(1'b1, 32'h30);
    at_neg();
    check_gnt("recover", 1'b1, 1'b0);
    i_exp_q.push_back({1'b0, 32'hCAFE_F00D});
    tick();
    set_i(1'b0, '0);
    tick();
    tick();

    // final report
    check("i_queue_drained", 64'(i_exp_q.size()), 64'd0);
    check("d_queue_drained", 64'(d_exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  function automatic logic [3:0] BE_ALL_TB();
    return 4'hF;
  endfunction

endmodule
